// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction fetch and decode stages.
//   ISIZE / MSIZE   : instruction word width / address and PC width
//   *_HI / *_LO     : bit positions of the rd, rs, rt and funct fields
//   funct_e         : FPU operation selected by the funct field
//   fetch_state_e   : fetch controller states
//   word_align()    : clears the byte-offset bits of an address
package isa_pkg;

    localparam int unsigned ISIZE = 17;
    localparam int unsigned MSIZE = 32;

    localparam int unsigned RD_HI    = 16;
    localparam int unsigned RD_LO    = 12;
    localparam int unsigned RS_HI    = 11;
    localparam int unsigned RS_LO    = 7;
    localparam int unsigned RT_HI    = 6;
    localparam int unsigned RT_LO    = 2;
    localparam int unsigned FUNCT_HI = 1;
    localparam int unsigned FUNCT_LO = 0;

    typedef enum logic [1:0] {
        FADD = 2'd0,
        FSUB = 2'd1,
        FMUL = 2'd2,
        FDIV = 2'd3
    } funct_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } fetch_state_e;

    function automatic logic [MSIZE-1:0] word_align(input logic [MSIZE-1:0] addr);
        return addr & ~MSIZE'(3);
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-to-decode handshake bundle.
//   out_valid  : fetched instruction available (fetch -> decode)
//   out_ready  : decode accepts this cycle (decode -> fetch)
//   out_inst   : raw instruction word
//   out_pc     : address the word was fetched from
//   out_rd/rs/rt/out_funct : pre-split instruction fields
// Modports: master = fetch side, slave = decode side.
interface ifetch_unit_if;
    import isa_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [ISIZE-1:0] out_inst;
    logic [MSIZE-1:0] out_pc;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [1:0]       out_funct;

    modport master (
        output out_valid, out_inst, out_pc, out_rd, out_rs, out_rt, out_funct,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_inst, out_pc, out_rd, out_rs, out_rt, out_funct,
        output out_ready
    );

endinterface

// File: rtl/inst_field_split.sv
// Combinational split of an instruction word into its register and funct fields.
//   inst  : ISIZE-bit instruction word
//   rd    : inst[16:12]
//   rs    : inst[11:7]
//   rt    : inst[6:2]
//   funct : inst[1:0] as funct_e
module inst_field_split
    import isa_pkg::*;
(
    input  logic [ISIZE-1:0] inst,
    output logic [4:0]       rd,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output funct_e           funct
);

    always_comb begin
        rd    = inst[RD_HI:RD_LO];
        rs    = inst[RS_HI:RS_LO];
        rt    = inst[RT_HI:RT_LO];
        funct = funct_e'(inst[FUNCT_HI:FUNCT_LO]);
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory and
// presents each fetched word to decode over a valid/ready handshake.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : begin fetching at START_ADDR (honoured in IDLE/HALT)
//   IP             : instruction pointer to memory (equals pc)
//   Inst           : instruction word from memory, combinational in IP
//   redirect_valid : load redirect_addr (word aligned) and flush the output
//   redirect_addr  : new PC
//   dec            : fetch-to-decode handshake (master side)
//   halted         : high while in HALT
//   fetch_count    : delivered instructions, saturating at 0xFFFF
module ifetch_unit #(
    parameter int unsigned ISIZE      = isa_pkg::ISIZE,
    parameter int unsigned MSIZE      = isa_pkg::MSIZE,
    parameter int unsigned START_ADDR = 4,
    parameter int unsigned LAST_ADDR  = 1020,
    parameter int unsigned STEP       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [MSIZE-1:0] IP,
    input  logic [ISIZE-1:0] Inst,
    input  logic             redirect_valid,
    input  logic [MSIZE-1:0] redirect_addr,
    ifetch_unit_if.master    dec,
    output logic             halted,
    output logic [15:0]      fetch_count
);
    import isa_pkg::*;

    fetch_state_e     state;
    logic [MSIZE-1:0] pc;
    logic             valid_q;
    logic [ISIZE-1:0] inst_q;
    logic [MSIZE-1:0] pc_q;
    logic [4:0]       rd_q;
    logic [4:0]       rs_q;
    logic [4:0]       rt_q;
    logic [1:0]       funct_q;
    logic             halted_q;
    logic [15:0]      count_q;

    logic [4:0]       rd_w;
    logic [4:0]       rs_w;
    logic [4:0]       rt_w;
    funct_e           funct_w;

    logic             free;
    logic             handshake;
    logic             redir;

    inst_field_split u_split (
        .inst  (Inst),
        .rd    (rd_w),
        .rs    (rs_w),
        .rt    (rt_w),
        .funct (funct_w)
    );

    always_comb begin
        free      = !valid_q || dec.out_ready;
        handshake = valid_q && dec.out_ready;
        // Redirect is ignored before the first start.
        redir     = redirect_valid && (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= MSIZE'(START_ADDR);
            valid_q  <= 1'b0;
            inst_q   <= '0;
            pc_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            funct_q  <= '0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // A word flushed by a redirect is never counted as delivered.
            if (handshake && !redir && count_q != '1)
                count_q <= count_q + 16'd1;

            if (redir) begin
                pc       <= word_align(redirect_addr);
                valid_q  <= 1'b0;
                state    <= FETCH;
                halted_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (handshake)
                            valid_q <= 1'b0;
                        if (start) begin
                            state <= FETCH;
                            pc    <= MSIZE'(START_ADDR);
                        end
                    end
                    HALT: begin
                        if (handshake)
                            valid_q <= 1'b0;
                        if (start) begin
                            state    <= FETCH;
                            pc       <= MSIZE'(START_ADDR);
                            count_q  <= '0;
                            halted_q <= 1'b0;
                        end
                    end
                    FETCH: begin
                        if (free) begin
                            // Past the last address or a zero halt marker:
                            // stop with the PC parked, nothing captured.
                            if (pc > MSIZE'(LAST_ADDR) || Inst == '0) begin
                                valid_q  <= 1'b0;
                                state    <= HALT;
                                halted_q <= 1'b1;
                            end else begin
                                valid_q <= 1'b1;
                                inst_q  <= Inst;
                                pc_q    <= pc;
                                rd_q    <= rd_w;
                                rs_q    <= rs_w;
                                rt_q    <= rt_w;
                                funct_q <= funct_w;
                                pc      <= pc + MSIZE'(STEP);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign IP            = pc;
    assign halted        = halted_q;
    assign fetch_count   = count_q;
    assign dec.out_valid = valid_q;
    assign dec.out_inst  = inst_q;
    assign dec.out_pc    = pc_q;
    assign dec.out_rd    = rd_q;
    assign dec.out_rs    = rs_q;
    assign dec.out_rt    = rt_q;
    assign dec.out_funct = funct_q;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage: the reading side of the 17-bit instruction memory.
- Owns the program counter and drives the memory address, which is a 32-bit byte address stepping by 4.
- Captures the combinational instruction word, splits it into register and funct fields, and hands it to decode over a valid/ready handshake.
- Handles start, stall, redirect and halt; sits between the instruction memory and the FPU decode/issue stage.

Parameters:
- ISIZE, 17, instruction width.
- MSIZE, 32, address/PC width.
- START_ADDR, 4, PC loaded on start; word 0 is reserved (always zero).
- LAST_ADDR, 1020, highest fetchable address; PC beyond this halts.
- STEP, 4, PC increment per instruction.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, pulse: begin fetching at START_ADDR. Honoured only in IDLE or HALT.
- IP, output, MSIZE, instruction pointer to memory; equals pc register.
- Inst, input, ISIZE, instruction word from memory; combinational in IP.
- redirect_valid, input, 1, load new PC (flush).
- redirect_addr, input, MSIZE, new PC; bits [1:0] forced to 0.
- out_valid, output, 1, fetched instruction available.
- out_ready, input, 1, decode accepts this cycle.
- out_inst, output, ISIZE, raw instruction word.
- out_pc, output, MSIZE, address the word was fetched from.
- out_rd, output, 5, Inst[16:12].
- out_rs, output, 5, Inst[11:7].
- out_rt, output, 5, Inst[6:2].
- out_funct, output, 2, Inst[1:0]: 00 add, 01 sub, 10 mul, 11 div.
- halted, output, 1, high in HALT.
- fetch_count, output, 16, instructions delivered (handshakes), saturating at 0xFFFF.

Behaviour:
- Reset (async): state=IDLE, pc=START_ADDR, out_valid=0, out_inst/out_pc/fields=0, halted=0, fetch_count=0.
- States:
  - IDLE: wait for start, then FETCH with pc=START_ADDR.
  - FETCH: issue fetches; go to HALT on the halt conditions below.
  - HALT: halted=1. start goes to FETCH with pc=START_ADDR and fetch_count cleared; redirect goes to FETCH with pc=redirect_addr.
- Output register "free" = !out_valid || out_ready.
- FETCH with free and pc<=LAST_ADDR:
  - Inst != 0: capture Inst, pc, fields; out_valid<=1 next cycle; pc<=pc+STEP. Latency is 1 cycle from IP to out_valid.
  - Inst == 0: halt marker. Not delivered; out_valid<=0 if the current word is consumed; go to HALT. pc holds.
- FETCH with free and pc>LAST_ADDR: go to HALT; nothing captured.
- Not free (stall): pc and the output register hold, all outputs stable. Decode must see identical values until a handshake.
- Handshake: out_valid && out_ready. fetch_count increments and saturates.
- In HALT or IDLE, a pending out_valid word stays presented until consumed.
- redirect_valid beats start, stall and the halt decision, in any state except IDLE:
  - next cycle pc=redirect_addr&~3, out_valid=0 (in-flight word dropped, not counted), state=FETCH.
  - The first redirected word appears 2 cycles after redirect.
- start in FETCH is ignored. start and redirect in the same cycle: redirect wins.
- PC increment uses MSIZE-bit wrap arithmetic; the LAST_ADDR check prevents a real wrap.
- rst mid-stream aborts immediately to the reset values; no word is delivered.

Decomposition:
- Shared package (isa_pkg):
  - ISIZE, MSIZE.
  - Field bit positions (RD_HI/LO, RS_HI/LO, RT_HI/LO, FUNCT_HI/LO).
  - funct_e enum: FADD=0, FSUB=1, FMUL=2, FDIV=3.
  - fetch_state_e: IDLE, FETCH, HALT.
- One sub-module, inst_field_split: combinational ISIZE word into rd/rs/rt/funct. Reused by the decode stage.

Test Plan:
- Reset, start; memory holds 0x0A310 @4, 0x03118 @8, 0x0C5AC @12, 0x14AD8 @16, 0 @20; out_ready=1.
  - IP=4,8,12,16 on consecutive cycles.
  - out_inst sequence as loaded; first word gives rd=10, rs=6, rt=4, funct=0.
  - HALT with halted=1 after the @20 fetch; fetch_count=4.
- Same program, out_ready low for 3 cycles while out_pc=8:
  - out_inst=0x03118 and IP=12 held stable throughout.
  - Resumes without loss or duplication; fetch_count=4.
- Redirect to 0x46 while out_pc=8 is valid and unaccepted:
  - Word dropped; out_valid=0 next cycle.
  - Then out_pc=0x44, out_funct=2 (mul word 0x0C5AE).
- From HALT: start gives IP=4 and fetch_count=0. Redirect gives IP=redirect_addr.
  - start together with redirect=36: IP=36.
- Fill memory to LAST_ADDR with nonzero words:
  - PC reaches 1020, delivers 255 words, then HALT.
  - IP never exceeds 1024.
- Assert rst mid-stall with out_valid=1:
  - Immediately out_valid=0, IP=4, state IDLE, fetch_count=0.
